// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_NUM_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The controlling FSM uses the master modport, the subtractor the slave.
interface serial_subtractor_8bit_if #(
    parameter int NUM_BITS = serial_sub_pkg::DEFAULT_NUM_BITS
) ();
    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                borrow_in;
    logic [NUM_BITS-1:0] diff;
    logic                borrow_out;
    logic                busy;
    logic                done;

    modport master (
        output start, a, b, borrow_in,
        input  diff, borrow_out, busy, done
    );

    modport slave (
        input  start, a, b, borrow_in,
        output diff, borrow_out, busy, done
    );
endinterface

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB
// first, through a single full_subtractor_1bit cell.
// Build option: define SERIAL_SUB_SATURATE_EN to clamp an underflowing
// result to zero (borrow_out still reports the underflow).
module serial_subtractor_8bit
    import serial_sub_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_8bit_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] a_sh_q, a_sh_d;
    logic [NUM_BITS-1:0] b_sh_q, b_sh_d;
    logic                br_q, br_d;
    logic [NUM_BITS-1:0] res_q, res_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                borrow_out_q, borrow_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_d_s;
    logic                bit_bout_s;
    logic [NUM_BITS-1:0] res_next_s;

    // The only arithmetic element: works on the current LSBs and running borrow.
    full_subtractor_1bit u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (bit_d_s),
        .bout (bit_bout_s)
    );

    // Result bits enter from the MSB side so that after the last bit the
    // register holds the difference in natural order.
    assign res_next_s = {bit_d_s, res_q[NUM_BITS-1:1]};

    // Next-state, datapath shifting and output-register updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        br_d         = br_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = bus.borrow_in;
                    res_d   = {NUM_BITS{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_sh_d = {1'b0, a_sh_q[NUM_BITS-1:1]};
                b_sh_d = {1'b0, b_sh_q[NUM_BITS-1:1]};
                br_d   = bit_bout_s;
                res_d  = res_next_s;
                if (cnt_q == LAST_BIT) begin
                    cnt_d        = {CNT_W{1'b0}};
                    state_d      = DONE;
                    done_d       = 1'b1;
                    borrow_out_d = bit_bout_s;
`ifdef SERIAL_SUB_SATURATE_EN
                    if (bit_bout_s) begin
                        diff_d = {NUM_BITS{1'b0}};
                    end else begin
                        diff_d = res_next_s;
                    end
`else
                    diff_d = res_next_s;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
    end

    // State, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            a_sh_q       <= {NUM_BITS{1'b0}};
            b_sh_q       <= {NUM_BITS{1'b0}};
            br_q         <= 1'b0;
            res_q        <= {NUM_BITS{1'b0}};
            diff_q       <= {NUM_BITS{1'b0}};
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            br_q         <= br_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Scoreboard bench for serial_subtractor_8bit: the driver pushes the
// arithmetic expectation of every accepted operation, an independent monitor
// pops and compares on each done pulse.
module tb_serial_subtractor_8bit;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] diff;
        logic         bout;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t exp_q[$];
    logic [N-1:0] exp_last_diff;

    serial_subtractor_8bit_if #(.NUM_BITS(N)) bus ();

    serial_subtractor_8bit #(.NUM_BITS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        exp_t e;
        int   r;
        r      = int'(a) - int'(b) - int'(bin);
        e.a    = a;
        e.b    = b;
        e.bin  = bin;
        e.bout = (r < 0);
        e.diff = N'((r + 256) % 256);
`ifdef SERIAL_SUB_SATURATE_EN
        if (e.bout) e.diff = '0;
`endif
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("diff", 32'(bus.diff), 32'(e.diff));
                    check("borrow_out", 32'(bus.borrow_out), 32'(e.bout));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
`ifndef SERIAL_SUB_SATURATE_EN
                    check("adder_identity", 32'((bus.diff + e.b + N'(e.bin)) & 8'hFF), 32'(e.a));
`endif
                    exp_last_diff = e.diff;
                end
            end else if (bus.busy) begin
                check("diff_stable", 32'(bus.diff), 32'(exp_last_diff));
            end
        end
    end

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
        bus.start     = 1'b1;
        exp_q.push_back(model(a, b, bin));
    endtask

    // Wait (bounded) for done after a start issued at the current negedge.
    // With hold_start the start line stays high with junk operands while busy.
    task automatic wait_done(input bit hold_start);
        int k;
        int bc;
        k  = 0;
        bc = 0;
        do begin
            @(negedge clk);
            k++;
            if (hold_start) begin
                bus.a         = N'($urandom);
                bus.b         = N'($urandom);
                bus.borrow_in = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) bc++;
        end while (!bus.done && k < 40);
        bus.start = 1'b0;
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(k - 1), 32'(N));
        check("busy_cycles", 32'(bc), 32'(N));
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        start_op(a, b, bin);
        wait_done(1'b0);
        @(negedge clk);
    endtask

    initial begin
        int dones;
        errors        = 0;
        checks        = 0;
        exp_last_diff = '0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_borrow_out", 32'(bus.borrow_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including wrap/underflow and borrow-in boundaries.
        run_op(8'h5A, 8'h23, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h00, 8'hFF, 1'b1);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);

        // Back-to-back: start held high through busy and re-asserted in DONE.
        start_op(8'hC3, 8'h3C, 1'b0);
        wait_done(1'b1);
        start_op(8'h10, 8'h20, 1'b1);
        wait_done(1'b0);
        @(negedge clk);
        check("idle_after_single", 32'(bus.busy), 32'd0);

        start_op(8'h44, 8'h11, 1'b0);
        wait_done(1'b1);
        start_op(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        check("no_idle_between", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        // Continue the bounded wait for the second done.
        begin
            int k;
            k = 1;
            while (!bus.done && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("b2b_done_seen", 32'(bus.done), 32'd1);
            check("b2b_latency", 32'(k - 1), 32'(N));
        end
        @(negedge clk);

        // Reset in the middle of CALC aborts the operation with no done.
        start_op(8'h77, 8'h12, 1'b0);
        repeat (5) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        exp_last_diff = '0;
        #1;
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_borrow_out", 32'(bus.borrow_out), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("no_done_after_abort", 32'(dones), 32'd0);
        run_op(8'h9C, 8'h4E, 1'b1);

        // Randomised operations with random back-to-back chaining.
        for (int i = 0; i < 400; i++) begin
            start_op(N'($urandom), N'($urandom), 1'($urandom));
            wait_done($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
